// File: rtl/store_buffer_lsu.sv
// store_buffer_lsu: MEM-stage load/store front end with an in-order store FIFO draining to a single memory port.
module store_buffer_lsu #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic                         req_store,
  input  logic [DM_ADDRESS-1:0]        req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [2:0]                   req_funct3,
  output logic                         req_ready,
  input  logic                         flush,
  output logic                         flush_done,
  output logic                         ld_valid,
  output logic [DATA_W-1:0]            ld_data,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [DM_ADDRESS-1:0]        mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [2:0]                   mem_funct3,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic [$clog2(DEPTH+1)-1:0]   sb_count,
  output logic                         sb_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  typedef enum logic {RUN, FLUSH} state_t;
  state_t state, state_next;
  logic [DM_ADDRESS-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];
  logic [2:0]            f3_q   [DEPTH];
  logic [DEPTH-1:0]      valid;
  logic [PW-1:0]         head, tail;
  logic [CW-1:0]         count, count_next;
  logic conflict, run, acc, ld_acc, st_acc, pop, flushing;
  // a load may not pass any buffered store to the same word
  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      conflict = conflict | (valid[i] && addr_q[i][DM_ADDRESS-1:2] == req_addr[DM_ADDRESS-1:2]);
  end
  assign run        = state == RUN && !flush;
  assign req_ready  = run && (req_store ? count < CW'(DEPTH) : !conflict);
  assign acc        = req_valid && req_ready;
  assign ld_acc     = acc && !req_store;
  assign st_acc     = acc && req_store;
  // loads own the port; otherwise the head store drains
  assign pop        = !ld_acc && count != '0;
  assign mem_read   = ld_acc;
  assign mem_write  = pop;
  assign mem_addr   = ld_acc ? req_addr : pop ? addr_q[head] : '0;
  assign mem_wdata  = pop ? data_q[head] : '0;
  assign mem_funct3 = ld_acc ? req_funct3 : pop ? f3_q[head] : '0;
  assign count_next = count + CW'(st_acc) - CW'(pop);
  assign flushing   = state == FLUSH || flush;
  assign state_next = (flushing && count_next != '0) ? FLUSH : RUN;
  assign sb_count   = count;
  assign sb_empty   = count == '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      valid      <= '0;
      ld_valid   <= 1'b0;
      ld_data    <= '0;
      flush_done <= 1'b0;
    end else begin
      state      <= state_next;
      count      <= count_next;
      flush_done <= flushing && count_next == '0;
      ld_valid   <= ld_acc;
      if (ld_acc) ld_data <= mem_rdata;
      if (pop) begin
        valid[head] <= 1'b0;
        head        <= head + 1'b1;
      end
      if (st_acc) begin
        valid[tail]  <= 1'b1;
        addr_q[tail] <= req_addr;
        data_q[tail] <= req_wdata;
        f3_q[tail]   <= req_funct3;
        tail         <= tail + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_store_buffer_lsu.sv
// tb_store_buffer_lsu: random request/flush/reset traffic checked against a queue-based model of the store buffer.
module tb_store_buffer_lsu;
  logic        clk = 1'b0;
  logic        reset, req_valid, req_store, flush;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata, mem_rdata;
  logic [2:0]  req_funct3;
  logic        req_ready, flush_done, ld_valid, mem_read, mem_write, sb_empty;
  logic [31:0] ld_data, mem_wdata;
  logic [8:0]  mem_addr;
  logic [2:0]  mem_funct3, sb_count;

  store_buffer_lsu #(.DM_ADDRESS(9), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_store(req_store),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_funct3(req_funct3),
    .req_ready(req_ready), .flush(flush), .flush_done(flush_done),
    .ld_valid(ld_valid), .ld_data(ld_data), .mem_read(mem_read),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_funct3(mem_funct3), .mem_rdata(mem_rdata), .sb_count(sb_count),
    .sb_empty(sb_empty));

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  addr;
    logic [31:0] data;
    logic [2:0]  f3;
  } ent_t;

  ent_t        q[$];
  bit          m_flush, e_ldv, e_fd;
  logic [31:0] e_ldd;
  int          n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] rand_f3();
    logic [2:0] t [5];
    t = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    return t[$urandom_range(0, 4)];
  endfunction

  initial begin
    bit   confl, ready, lacc, sacc, drain;
    int   store_pct;
    reset = 1'b1; req_valid = 0; req_store = 0; req_addr = 0; req_wdata = 0;
    req_funct3 = 0; flush = 0; mem_rdata = 0;
    m_flush = 0; e_ldv = 0; e_fd = 0; e_ldd = 0;
    repeat (2) @(posedge clk);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      #1;
      store_pct  = ((cyc / 200) % 3 == 0) ? 85 : ((cyc / 200) % 3 == 1) ? 50 : 20;
      reset      = cyc > 5 && $urandom_range(0, 99) < 1;
      flush      = $urandom_range(0, 99) < 4;
      req_valid  = $urandom_range(0, 99) < 75;
      req_store  = $urandom_range(0, 99) < store_pct;
      req_addr   = ($urandom_range(0, 9) < 8) ? {4'(0), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))}
                                               : 9'($urandom_range(0, 511));
      req_wdata  = $urandom;
      req_funct3 = rand_f3();
      mem_rdata  = $urandom;
      #1;
      confl = 0;
      foreach (q[i]) if (q[i].addr[8:2] == req_addr[8:2]) confl = 1;
      ready = !m_flush && !flush && (req_store ? q.size() < 4 : !confl);
      lacc  = req_valid && ready && !req_store;
      sacc  = req_valid && ready && req_store;
      drain = !lacc && q.size() > 0;
      if (!reset) begin
        check("sb_count", 32'(sb_count), 32'(q.size()));
        check("sb_empty", 32'(sb_empty), 32'(q.size() == 0));
        check("ld_valid", 32'(ld_valid), 32'(e_ldv));
        check("ld_data", ld_data, e_ldd);
        check("flush_done", 32'(flush_done), 32'(e_fd));
        check("req_ready", 32'(req_ready), 32'(ready));
        check("mem_read", 32'(mem_read), 32'(lacc));
        check("mem_write", 32'(mem_write), 32'(drain));
        if (lacc) begin
          check("ld_addr", 32'(mem_addr), 32'(req_addr));
          check("ld_f3", 32'(mem_funct3), 32'(req_funct3));
        end else if (drain) begin
          check("st_addr", 32'(mem_addr), 32'(q[0].addr));
          check("st_data", mem_wdata, q[0].data);
          check("st_f3", 32'(mem_funct3), 32'(q[0].f3));
        end else begin
          check("idle_addr", 32'(mem_addr), 32'd0);
          check("idle_data", mem_wdata, 32'd0);
          check("idle_f3", 32'(mem_funct3), 32'd0);
        end
      end
      if (reset) begin
        q.delete();
        m_flush = 0; e_ldv = 0; e_fd = 0; e_ldd = 0;
      end else begin
        if (drain) void'(q.pop_front());
        if (sacc) q.push_back('{req_addr, req_wdata, req_funct3});
        e_ldv = lacc;
        if (lacc) e_ldd = mem_rdata;
        e_fd    = (m_flush || flush) && q.size() == 0;
        m_flush = (m_flush || flush) && q.size() != 0;
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
